key_debounce_pulse: RTL

- Debounces one raw mechanical push-button and emits single-cycle press/release flags.
- Sits directly upstream of timer_start. key_press_flag drives timer_start_flag, so one physical press starts exactly one timer run.
- Also exports the debounced level for LEDs or status.

---
 rtl/key_debounce_pulse_pkg.sv | 27 ++
 rtl/key_debounce_pulse_sync_2ff.sv | 27 ++
 rtl/key_debounce_pulse.sv | 127 ++++++++++++
 3 files changed

// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and
// constant helpers used to size the debounce counter.
package key_debounce_pulse_pkg;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Ceiling log2; callers pass N+1 so the result is never 0.
    function automatic int clog2(input int value);
        int v;
        int w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    function automatic int debounce_cycles(input int clk_freq, input int debounce_ms);
        return clk_freq / 1000 * debounce_ms;
    endfunction

endpackage

// File: rtl/key_debounce_pulse_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin; both flops reset to
// RST_VAL so the output reads the idle level right after reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button debouncer: synchronizes the raw pin, requires N stable cycles
// before changing the debounced level, and emits one-cycle press/release flags.
module key_debounce_pulse
    import key_debounce_pulse_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_in,
    output logic       key_state,
    output logic       key_press_flag,
    output logic       key_release_flag,
    output logic [1:0] o_dbg_state
);

    localparam int             N              = debounce_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int             CW             = clog2(N + 1);
    localparam logic [CW-1:0]  CNT_LAST       = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_ONE        = CW'(1);
    localparam logic           RELEASED_LEVEL = (KEY_ACTIVE_LOW != 0);

    logic          w_key_pin_sync;
    logic          w_key_sync;
    logic          w_cnt_done;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic          r_key_state;
    logic          w_key_state_nxt;
    logic          r_press;
    logic          w_press_nxt;
    logic          r_release;
    logic          w_release_nxt;

    sync_2ff #(
        .RST_VAL (RELEASED_LEVEL)
    ) u_sync (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_d   (key_in),
        .o_q   (w_key_pin_sync)
    );

    // XOR with the idle pin level yields 1 = pressed for either polarity.
    assign w_key_sync = w_key_pin_sync ^ RELEASED_LEVEL;
    assign w_cnt_done = (r_cnt >= CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_RELEASED;
            r_cnt       <= '0;
            r_key_state <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_state <= w_key_state_nxt;
            r_press     <= w_press_nxt;
            r_release   <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_RELEASED: begin
                if (w_key_sync) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_key_sync) begin
                    w_state_nxt = ST_RELEASED;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!w_key_sync) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_key_sync) begin
                    w_state_nxt = ST_PRESSED;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_RELEASED;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
            end
        endcase
    end

    // Flags are computed from the same exit conditions as the WAIT states.
    always_comb begin
        w_press_nxt     = (r_state == ST_PRESS_WAIT) && w_key_sync && w_cnt_done;
        w_release_nxt   = (r_state == ST_RELEASE_WAIT) && !w_key_sync && w_cnt_done;
        w_key_state_nxt = r_key_state;
        if (w_press_nxt) begin
            w_key_state_nxt = 1'b1;
        end else if (w_release_nxt) begin
            w_key_state_nxt = 1'b0;
        end
    end

    assign key_state        = r_key_state;
    assign key_press_flag   = r_press;
    assign key_release_flag = r_release;
    assign o_dbg_state      = r_state;

endmodule
